// File: rtl/nanci_app_pkg.sv
// Shared definitions for the Nanci per-node application.
//   - address-pattern mode encodings
//   - application state enum
//   - bit positions of the fields in the request/result words
package nanci_app_pkg;

    localparam int MODE_OPPOSITE  = 0;
    localparam int MODE_NEIGHBOUR = 1;
    localparam int MODE_STRIDE    = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Word layout, MSB first: {flag, address, data}.
    // The flag is "valid" on results and "write" on requests.
    localparam int DATA_LSB = 0;

    function automatic int addr_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int flag_pos(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

endpackage

// File: rtl/app_addr_gen.sv
// Combinational address generator: maps request index k to a target node
// address for the selected pattern. Used both by the issue path and by the
// optional result checker.
//   k    : request index
//   addr : target node address, modulo N by truncation
module app_addr_gen
    import nanci_app_pkg::*;
#(
    parameter int N          = 1024,
    parameter int I          = 0,
    parameter int MODE       = 0,
    parameter int STRIDE     = 1,
    parameter int NUM_REQ    = 1,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int KW         = 1
) (
    input  logic [KW-1:0]         k,
    output logic [ADDR_WIDTH-1:0] addr
);

    // Stride product is kept wide enough for k*STRIDE before wrapping.
    localparam int PW = ADDR_WIDTH + $clog2(NUM_REQ) + 1;

    logic [PW-1:0] sum;

    always_comb begin
        sum = '0;
        if (MODE == MODE_NEIGHBOUR)
            sum = PW'(I + 1) + PW'(k);
        else if (MODE == MODE_STRIDE)
            sum = PW'(I) + PW'(k) * PW'(STRIDE);
        else
            sum = PW'(N - 1 - I);
        addr = sum[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/application_pattern.sv
// Per-node Nanci application: issues NUM_REQ reads on runnable slots using a
// selectable address pattern, sums the returned data and writes the sum back
// to its own address I at the first slot after the last response.
//   clk, rst       : clock, asynchronous active-high reset
//   runnable       : one-cycle slot pulse, at most one request per pulse
//   nanci_result   : {valid, source address, data}
//   app_request    : {write, address, data}, registered and held between slots
//   compute_cycles : constant COMPUTE_CYCLES
//   err            : sticky result-address mismatch flag
// Optional feature: define APP_RESULT_CHECK_EN to build the result checker;
// otherwise err is tied low.
module application_pattern
    import nanci_app_pkg::*;
#(
    parameter int N              = 1024,
    parameter int I              = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int MODE           = 0,
    parameter int NUM_REQ        = 1,
    parameter int STRIDE         = 1,
    parameter int COMPUTE_CYCLES = 5,
    localparam int ADDR_WIDTH    = $clog2(N)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             runnable,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0]   nanci_result,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]   app_request,
    output logic [13:0]                      compute_cycles,
    output logic                             err
);

    localparam int FLAG = flag_pos(ADDR_WIDTH, DATA_WIDTH);
    localparam int ALSB = addr_lsb(DATA_WIDTH);
    localparam int KW   = $clog2(NUM_REQ + 1);
    localparam logic [DATA_WIDTH-1:0] I_DATA = DATA_WIDTH'(I);
    localparam logic [ADDR_WIDTH-1:0] I_ADDR = ADDR_WIDTH'(I);

    logic                  res_vld;
    logic [ADDR_WIDTH-1:0] res_src;
    logic [DATA_WIDTH-1:0] res_data;

    assign res_vld  = nanci_result[FLAG];
    assign res_src  = nanci_result[FLAG-1:ALSB];
    assign res_data = nanci_result[DATA_WIDTH-1:DATA_LSB];

    state_t                state;
    logic [KW-1:0]         k;
    logic [KW-1:0]         r;
    logic [DATA_WIDTH-1:0] acc;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // A result counts only while reads are outstanding.
    logic          take;
    logic [KW-1:0] r_next;
    logic          resp_done;

    assign take      = res_vld && (state == S_ISSUE || state == S_WAIT) &&
                       (r != KW'(NUM_REQ));
    assign r_next    = r + KW'(take);
    assign resp_done = (r_next == KW'(NUM_REQ));

    assign compute_cycles = 14'(COMPUTE_CYCLES);

    app_addr_gen #(
        .N(N), .I(I), .MODE(MODE), .STRIDE(STRIDE), .NUM_REQ(NUM_REQ),
        .ADDR_WIDTH(ADDR_WIDTH), .KW(KW)
    ) u_issue_addr (
        .k    (k),
        .addr (issue_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            app_request <= '0;
            k           <= '0;
            r           <= '0;
            acc         <= '0;
        end else begin
            if (take) begin
                acc <= acc + res_data;
                r   <= r_next;
            end
            case (state)
                S_IDLE: if (runnable) begin
                    app_request <= {1'b0, issue_addr, I_DATA};
                    k           <= k + KW'(1);
                    state       <= (NUM_REQ == 1) ? S_WAIT : S_ISSUE;
                end
                S_ISSUE: if (runnable) begin
                    app_request <= {1'b0, issue_addr, I_DATA};
                    k           <= k + KW'(1);
                    // Final response may land alongside the final issue.
                    if (k == KW'(NUM_REQ - 1))
                        state <= resp_done ? S_WRITE : S_WAIT;
                end
                S_WAIT: if (resp_done) state <= S_WRITE;
                S_WRITE: if (runnable) begin
                    // r == NUM_REQ here, so no further result can be added.
                    app_request <= {1'b1, I_ADDR, acc};
                    state       <= S_DONE;
                end
                default: ;
            endcase
        end
    end

`ifdef APP_RESULT_CHECK_EN
    // Results return in issue order, so the r-th result must come from addr(r).
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  err_q;

    app_addr_gen #(
        .N(N), .I(I), .MODE(MODE), .STRIDE(STRIDE), .NUM_REQ(NUM_REQ),
        .ADDR_WIDTH(ADDR_WIDTH), .KW(KW)
    ) u_chk_addr (
        .k    (r),
        .addr (exp_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (take && res_src != exp_addr)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_src;
    assign unused_src = ^res_src;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_application_pattern.sv
// Bench for application_pattern: three instances (opposite, neighbour with
// wrap, stride with wrap) driven with random slots and results, checked
// against a queue-based reference model at the request/response level.
module tb_application_pattern;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  run;
    logic [36:0] res_a, res_b, req_a, req_b;
    logic [38:0] res_c, req_c;
    logic [13:0] cc_a, cc_b, cc_c;
    logic        err_a, err_b, err_c;

    application_pattern #(.N(16), .I(3), .MODE(0), .NUM_REQ(1)) u_a (
        .clk(clk), .rst(rst), .runnable(run[0]), .nanci_result(res_a),
        .app_request(req_a), .compute_cycles(cc_a), .err(err_a));
    application_pattern #(.N(16), .I(14), .MODE(1), .NUM_REQ(3)) u_b (
        .clk(clk), .rst(rst), .runnable(run[1]), .nanci_result(res_b),
        .app_request(req_b), .compute_cycles(cc_b), .err(err_b));
    application_pattern #(.N(64), .I(5), .MODE(2), .NUM_REQ(4), .STRIDE(20),
                          .COMPUTE_CYCLES(9)) u_c (
        .clk(clk), .rst(rst), .runnable(run[2]), .nanci_result(res_c),
        .app_request(req_c), .compute_cycles(cc_c), .err(err_c));

    localparam int NN [3] = '{16, 16, 64};
    localparam int II [3] = '{3, 14, 5};
    localparam int MD [3] = '{0, 1, 2};
    localparam int NR [3] = '{1, 3, 4};
    localparam int ST [3] = '{1, 1, 20};
    localparam int AW [3] = '{4, 4, 6};
    localparam int CC [3] = '{5, 5, 9};

    logic [38:0] req [3];
    logic [13:0] ccv [3];
    logic        errv [3];
    always_comb begin
        req[0] = {2'b00, req_a}; req[1] = {2'b00, req_b}; req[2] = req_c;
        ccv[0] = cc_a; ccv[1] = cc_b; ccv[2] = cc_c;
        errv[0] = err_a; errv[1] = err_b; errv[2] = err_c;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          iss [3];
    int          rcv [3];
    logic [31:0] sum [3];
    bit          wrote [3];
    bit          full_prev [3];
    bit          err_m [3];
    logic [38:0] last [3];
    logic [38:0] cur [3];
    logic [38:0] q0 [$];
    logic [38:0] q1 [$];
    logic [38:0] q2 [$];

    function automatic int ref_addr(input int d, input int k);
        if (MD[d] == 0) return NN[d] - 1 - II[d];
        if (MD[d] == 1) return (II[d] + 1 + k) % NN[d];
        return (II[d] + k * ST[d]) % NN[d];
    endfunction

    function automatic logic [38:0] pack(input int d, input bit f, input int a,
                                         input logic [31:0] dat);
        logic [63:0] e;
        e = 64'(dat) | (64'(a) << 32) | (64'(f) << (32 + AW[d]));
        return e[38:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [38:0] v);
        case (d)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop(input int d, output logic [38:0] v, output bit ok);
        ok = 1'b0; v = '0;
        case (d)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            iss[d] = 0; rcv[d] = 0; sum[d] = '0; wrote[d] = 0;
            full_prev[d] = 0; err_m[d] = 0; last[d] = '0; cur[d] = '0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Decide this cycle's inputs and the model's response to them.
    task automatic drive_cycle();
        for (int d = 0; d < 3; d++) begin
            bit          r_, v, cnt;
            int          src;
            logic [31:0] dat;
            logic [38:0] t;
            r_ = ($urandom_range(0, 2) == 0);
            v = 0; src = 0; dat = '0;
            if (!wrote[d] && iss[d] > 0 && rcv[d] < iss[d] && $urandom_range(0, 1) == 1) begin
                v = 1;
                src = ref_addr(d, rcv[d]);
                if ($urandom_range(0, 7) == 0) src = (src + 1) % NN[d];
                dat = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end else if ((wrote[d] || iss[d] == 0) && $urandom_range(0, 4) == 0) begin
                v = 1;   // stray result, must be ignored
                src = $urandom_range(0, NN[d] - 1);
                dat = $urandom;
            end
            cnt = v && iss[d] > 0 && rcv[d] < NR[d];
`ifdef APP_RESULT_CHECK_EN
            if (cnt && src != ref_addr(d, rcv[d])) err_m[d] = 1;
`endif
            if (r_) begin
                if (iss[d] < NR[d]) begin
                    last[d] = pack(d, 1'b0, ref_addr(d, iss[d]), 32'(II[d]));
                    iss[d]++;
                end else if (full_prev[d] && !wrote[d]) begin
                    last[d] = pack(d, 1'b1, II[d], sum[d]);
                    wrote[d] = 1;
                end
                push(d, last[d]);
            end
            if (cnt) begin
                sum[d] = sum[d] + dat;
                rcv[d]++;
            end
            full_prev[d] = (rcv[d] == NR[d]);
            run[d] = r_;
            t = v ? pack(d, 1'b1, src, dat) : '0;
            case (d)
                0: res_a = t[36:0];
                1: res_b = t[36:0];
                default: res_c = t;
            endcase
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk); #2;
        run = '0; res_a = '0; res_b = '0; res_c = '0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_req%0d", d), 64'(req[d]), 64'd0);
            check($sformatf("rst_err%0d", d), 64'(errv[d]), 64'd0);
            check($sformatf("rst_cc%0d", d), 64'(ccv[d]), 64'(CC[d]));
        end
        model_reset();
        @(posedge clk); #2 rst = 1'b0;
    endtask

    // Monitor: after each slot, pop the expected request; otherwise expect hold.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                logic [38:0] v;
                bit ok;
                if (run[d]) begin
                    pop(d, v, ok);
                    if (!ok) begin
                        checks++; errors++;
                        $display("FAIL sb_empty%0d actual=none required=entry", d);
                    end else cur[d] = v;
                end
                check($sformatf("req%0d", d), 64'(req[d]), 64'(cur[d]));
                check($sformatf("err%0d", d), 64'(errv[d]), 64'(err_m[d]));
                check($sformatf("cc%0d", d), 64'(ccv[d]), 64'(CC[d]));
            end
        end
    end

    initial begin
        rst = 1'b1; run = '0; res_a = '0; res_b = '0; res_c = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        do_reset();
        for (int round = 0; round < 14; round++) begin
            int len;
            len = (round % 3 == 0) ? 70 : $urandom_range(3, 40);
            for (int c = 0; c < len; c++) begin
                @(posedge clk); #2;
                drive_cycle();
            end
            do_reset();
        end
        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
